// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// MULU/DIVU sit beside the existing load opcode in the EX opcode space.
package ex_muldiv_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 6;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

  localparam logic [OPC_W-1:0] LDW  = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] MULU = OPC_W'(6'h19);
  localparam logic [OPC_W-1:0] DIVU = OPC_W'(6'h1b);

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // Working-register pair: {hi,lo} for multiply, {R,Q} for divide
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } step_t;

  function automatic logic is_muldiv_op(input logic [OPC_W-1:0] opc);
    return (opc == MULU) || (opc == DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-side request / write-back response bundle of the muldiv sequencer.
interface ex_muldiv_seq_if;
  import ex_muldiv_seq_pkg::*;

  logic                  start;
  logic [OPC_W-1:0]      opcode_in;
  logic [XLEN-1:0]       a_in;
  logic [XLEN-1:0]       b_in;
  logic [REG_W-1:0]      rwd_in;
  logic                  busy;
  logic                  done;
  logic [XLEN-1:0]       lo_out;
  logic [XLEN-1:0]       hi_out;
  logic [REG_W-1:0]      rwd_out;
  logic                  div0;

  modport master (
    output start, opcode_in, a_in, b_in, rwd_in,
    input  busy, done, lo_out, hi_out, rwd_out, div0
  );

  modport slave (
    input  start, opcode_in, a_in, b_in, rwd_in,
    output busy, done, lo_out, hi_out, rwd_out, div0
  );

endinterface

// File: rtl/ex_muldiv_seq_muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
module muldiv_step
  import ex_muldiv_seq_pkg::*;
(
  input  mode_e           mode_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output step_t           res_c_o
);

  logic [XLEN:0]   sum_c;
  logic [XLEN:0]   rsh_c;
  logic [XLEN-1:0] diff_c;
  logic            ge_c;

  always_comb begin
    res_c_o = '0;
    sum_c   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : (XLEN+1)'(0));
    rsh_c   = {hi_i, lo_i[XLEN-1]};
    // When no borrow occurs the difference is below the divisor, so 32 bits suffice
    ge_c    = (rsh_c >= {1'b0, opnd_i});
    diff_c  = rsh_c[XLEN-1:0] - opnd_i;

    if (mode_i == MODE_MUL) begin
      res_c_o.hi = sum_c[XLEN:1];
      res_c_o.lo = {sum_c[0], lo_i[XLEN-1:1]};
    end else if (ge_c) begin
      res_c_o.hi = diff_c;
      res_c_o.lo = {lo_i[XLEN-2:0], 1'b1};
    end else begin
      res_c_o.hi = rsh_c[XLEN-1:0];
      res_c_o.lo = {lo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative 32x32 MULU / 32/32 DIVU sequencer beside EX; stalls the front end
// via busy and hands a 64-bit result plus destination register to write-back.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [REG_W-1:0]  rwd_q, rwd_d;
  logic [XLEN-1:0]   lo_out_q, lo_out_d, hi_out_q, hi_out_d;
  logic [REG_W-1:0]  rwd_out_q, rwd_out_d;
  logic              busy_q, busy_d, done_q, done_d, div0_q, div0_d;
  logic              accept_c;
  mode_e             mode_c;
  step_t             step_c;

  assign accept_c = bus.start && is_muldiv_op(bus.opcode_in) &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
  assign mode_c   = (state_q == S_DIV_RUN) ? MODE_DIV : MODE_MUL;

  muldiv_step u_step (
    .mode_i  (mode_c),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .opnd_i  (opnd_q),
    .res_c_o (step_c)
  );

  // Next-state, working-register and result-register update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    rwd_d     = rwd_q;
    lo_out_d  = lo_out_q;
    hi_out_d  = hi_out_q;
    rwd_out_d = rwd_out_q;
    div0_d    = div0_q;

    case (state_q)
      S_MUL_RUN, S_DIV_RUN: begin
        hi_d  = step_c.hi;
        lo_d  = step_c.lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d   = S_DONE;
          lo_out_d  = step_c.lo;
          hi_out_d  = step_c.hi;
          rwd_out_d = rwd_q;
          if (state_q == S_DIV_RUN) div0_d = (opnd_q == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    // Accept overrides the DONE->IDLE return for back-to-back issue
    if (accept_c) begin
      cnt_d  = '0;
      div0_d = 1'b0;
      hi_d   = '0;
      rwd_d  = bus.rwd_in;
      if (bus.opcode_in == MULU) begin
        state_d = S_MUL_RUN;
        lo_d    = bus.b_in;
        opnd_d  = bus.a_in;
      end else begin
        state_d = S_DIV_RUN;
        lo_d    = bus.a_in;
        opnd_d  = bus.b_in;
      end
    end

    busy_d = (state_d == S_MUL_RUN) || (state_d == S_DIV_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      rwd_q     <= '0;
      lo_out_q  <= '0;
      hi_out_q  <= '0;
      rwd_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      rwd_q     <= rwd_d;
      lo_out_q  <= lo_out_d;
      hi_out_q  <= hi_out_d;
      rwd_out_q <= rwd_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.lo_out  = lo_out_q;
  assign bus.hi_out  = hi_out_q;
  assign bus.rwd_out = rwd_out_q;
  assign bus.div0    = div0_q;

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer attached beside the EX stage of the five-stage pipeline. It accepts one unsigned 32×32 multiply or 32/32 divide from EX, runs a 32-iteration shift-add or restoring-divide loop, and holds `busy` so the pipeline front end stalls. It then returns a 64-bit result and the destination register for write-back.

## Interface
Parameters:
- none; operand width is fixed at 32 bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request from EX, qualified by `opcode_in`.
- `opcode_in`  in  6  `MULU` or `DIVU`. Any other value leaves `start` ignored.
- `a_in`  in  32  multiplicand or dividend (EX `val_rs`).
- `b_in`  in  32  multiplier or divisor (EX `val_rt`).
- `rwd_in`  in  5  destination register of the request.
- `busy`  out  1  operation in flight; pipeline stalls IF/ID/EX while high.
- `done`  out  1  one-cycle pulse: results valid.
- `lo_out`  out  32  product[31:0] or quotient.
- `hi_out`  out  32  product[63:32] or remainder.
- `rwd_out`  out  5  destination register captured at accept.
- `div0`  out  1  last completed DIVU had divisor 0; cleared on the next accept.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- Accept happens when `start` = 1, `opcode_in` ∈ {`MULU`, `DIVU`}, and the state is IDLE or DONE.
  - On accept, latch `a_in`, `b_in`, `rwd_in`.
  - Clear the iteration counter (6 bits, 0..31) and `div0`.
  - Go to MUL_RUN or DIV_RUN.
- `start` in MUL_RUN or DIV_RUN is ignored; the request is not queued. Requests with an unsupported opcode are ignored in every state.
- MUL_RUN, one iteration per cycle, using a 64-bit accumulator {hi,lo} with lo initialised to the multiplier:
  - If lo[0] = 1, add the multiplicand to hi with a 33-bit sum.
  - Shift {carry,hi,lo} right by 1.
- DIV_RUN, restoring division, using remainder R (33-bit working value) and quotient Q initialised to the dividend:
  - Form {R,Q} << 1.
  - Compute T = R − divisor.
  - If T ≥ 0, set R = T and Q[0] = 1; otherwise Q[0] = 0.
- When the counter reaches 31 and that iteration completes, go to DONE and write `lo_out`/`hi_out`/`rwd_out` from the working registers.
  - For DIVU, set `div0` = (divisor == 0).
- Divide by zero is not special-cased in the datapath. The algorithm itself yields Q = 0xFFFFFFFF and R = dividend; only the `div0` flag is special.
- DONE lasts one cycle. The next state is IDLE, or a new RUN state if an accept occurs in DONE.
- Output registers hold their values until the next DONE entry.

## Timing
- Reset values: `busy` = 0, `done` = 0, `lo_out` = 0, `hi_out` = 0, `rwd_out` = 0, `div0` = 0, state = IDLE, all working registers 0.
- Accept at edge E; `busy` = 1 in the cycles after E through E+32.
- Iterations occur at edges E+1 … E+32.
- After edge E+32:
  - state = DONE.
  - `done` = 1 for exactly one cycle.
  - `busy` = 0.
  - Results are valid.
- Latency from accept to results is 32 cycles. With an accept in DONE, back-to-back throughput is one op per 33 cycles.
- `busy` and `done` are registered, decoded from state, and glitch-free.
- `rst_n` low at any time, including mid-RUN, immediately forces all registers to their reset values. The in-flight op is lost and `done` does not pulse.
- Operands are latched at accept, so changes to `a_in`/`b_in`/`rwd_in` during RUN have no effect.

## Structure
- Opcode constants `MULU` and `DIVU` are added to the shared `def.v` header next to `LDW`/`SDW`.
- State encodings are local `localparam`s.
- One sub-module: `muldiv_step`, a combinational single-iteration datapath. It takes mode, hi/R, lo/Q and the operand, and returns the next hi/R and lo/Q. The FSM, counter and output registers stay in `ex_muldiv_seq`.

## Test plan
- MULU with a = 0xFFFFFFFF, b = 0xFFFFFFFF, accepted at edge E:
  - `busy` high E+1 to E+32.
  - `done` pulses after E+32 with `hi_out` = 0xFFFFFFFE, `lo_out` = 0x00000001.
- DIVU with a = 100, b = 7, `rwd_in` = 5:
  - `lo_out` = 14, `hi_out` = 2, `rwd_out` = 5, `div0` = 0.
- DIVU with a = 0x1234, b = 0:
  - After 32 cycles, `lo_out` = 0xFFFFFFFF, `hi_out` = 0x1234, `div0` = 1.
  - The next accepted MULU clears `div0` at accept.
- Back-to-back:
  - MULU 3×5 followed by `start` held during RUN: extra requests are ignored.
  - DIVU 9/2 accepted in the DONE cycle: first result hi = 0, lo = 15; second result lo = 4, hi = 1, 33 cycles later.
- Reset mid-op: `rst_n` pulsed low at iteration 10 of a MULU.
  - All outputs read 0 asynchronously.
  - No `done` follows.
  - A new DIVU 7/7 afterwards returns lo = 1, hi = 0.
- `start` with `opcode_in` = `LDW`: `busy` stays 0 and no `done` pulse occurs.
